// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and decode-side valid/ready output.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_if;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  modport master (
    output o_imem_ren, o_imem_raddr, o_valid, o_inst, o_pc,
    input  i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_ren, o_imem_raddr, o_valid, o_inst, o_pc,
    output i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: PC + 1-cycle imem reads into a 2-entry {inst,pc} FIFO; request->o_valid is 2 cycles.
// Backpressure: issue stalls once FIFO plus in-flight word would exceed 2; head held while !i_ready.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic     i_clk,
  input logic     i_rst,
  fetch_if.master bus
);

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];

  logic        pop;
  logic [2:0]  occ;

  assign bus.o_valid      = (count != 2'd0) && !bus.i_redirect && !i_rst;
  assign pop              = bus.o_valid && bus.i_ready;
  // Occupancy the FIFO will reach once the outstanding response lands.
  assign occ              = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign bus.o_imem_ren   = !i_rst && !bus.i_redirect && (occ < 3'd2);
  assign bus.o_imem_raddr = pc;
  assign bus.o_inst       = q_inst[rd_ptr];
  assign bus.o_pc         = q_pc[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= RESET_ADDR;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else if (bus.i_redirect) begin
      // Flush everything, including the word still on its way back from memory.
      pc       <= bus.i_redirect_pc & ~32'h3;
      count    <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (inflight) begin
        q_inst[wr_ptr] <= bus.i_imem_rdata;
        q_pc[wr_ptr]   <= inflight_pc;
        wr_ptr         <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (bus.o_imem_ren) begin
        pc          <= pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: cycle table for reset/stall/redirect/wrap/reset-mid-stream, plus a
// randomized phase; every accepted word is checked against an expected-PC queue.
module tb_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Instruction memory: mem[a] = a ^ K, one cycle read latency.
  always @(posedge clk) begin
    if (bus.o_imem_ren) bus.i_imem_rdata <= bus.o_imem_raddr ^ K;
  end

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          e_ren;
    logic [31:0] e_raddr;
    bit          e_valid;
    logic [31:0] e_pc;
  } row_t;

  row_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          accepts  = 0;

  function automatic row_t mk(bit r, bit rdy, bit rd, logic [31:0] rpc,
                              bit eren, logic [31:0] eaddr, bit ev, logic [31:0] epc);
    row_t t;
    t.rst = r; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
    t.e_ren = eren; t.e_raddr = eaddr; t.e_valid = ev; t.e_pc = epc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic sb_restart(input logic [31:0] addr);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(addr + 32'(i * 4));
  endtask

  // Drive one cycle of inputs, then check any handshake that completes this cycle.
  task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    rst               = r;
    bus.i_ready       = rdy;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    #1;
    if (r) sb_restart(32'h0000_0000);
    else if (rd) sb_restart({rpc[31:2], 2'b00});
    if (bus.o_valid && rdy) begin
      accepts++;
      if (exp_q.size() == 0) begin
        chk("sb_empty", bus.o_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.o_pc, e);
        chk("sb_inst", bus.o_inst, e ^ K);
      end
    end
  endtask

  initial begin
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;

    // reset, then streaming from 0
    tbl.push_back(mk(1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h8,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'hC,1,32'h4));
    tbl.push_back(mk(0,1,0,0, 1,32'h10,1,32'h8));
    // backpressure: five stalled cycles, head held at 12
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0, 0,0,1,32'hC));
    tbl.push_back(mk(0,1,0,0, 1,32'h14,1,32'hC));
    tbl.push_back(mk(0,1,0,0, 1,32'h18,1,32'h10));
    tbl.push_back(mk(0,1,0,0, 1,32'h1C,1,32'h14));
    // redirect with a word queued and one in flight
    tbl.push_back(mk(0,1,1,32'h0000_1002, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h1000,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h1004,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h1008,1,32'h1000));
    // redirect while decode is ready for a valid head
    tbl.push_back(mk(0,1,1,32'h0000_2000, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h2000,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h2004,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h2008,1,32'h2000));
    // address wrap
    tbl.push_back(mk(0,1,1,32'hFFFF_FFF8, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'hFFFF_FFF8,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'hFFFF_FFFC,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,1,32'hFFFF_FFF8));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,1,0,0, 1,32'h8,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'hC,1,32'h4));
    // one-cycle reset mid-stream
    tbl.push_back(mk(1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h8,1,32'h0));
    tbl.push_back(mk(0,1,0,0, 1,32'hC,1,32'h4));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("row%0d ren", i), {31'b0, bus.o_imem_ren}, {31'b0, tbl[i].e_ren});
      if (tbl[i].e_ren) chk($sformatf("row%0d raddr", i), bus.o_imem_raddr, tbl[i].e_raddr);
      chk($sformatf("row%0d valid", i), {31'b0, bus.o_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d pc", i), bus.o_pc, tbl[i].e_pc);
        chk($sformatf("row%0d inst", i), bus.o_inst, tbl[i].e_pc ^ K);
      end
    end

    // random backpressure and occasional redirects; scoreboard checks every accept
    accepts = 0;
    for (int c = 0; c < 400; c++) begin
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom);
    end
    chk("rand_progress", {31'b0, accepts >= 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
